alu_datapath: RTL and testbench

Register-width arithmetic datapath for the execution unit. It contains an add/subtract core, a 2:1 operand-B select (register or instruction immediate) and a 4:1 write-back select. The write-back select chooses between the ALU result, the immediate, memory load data, and an operand-A pass-through. Combinational result paths feed the register file; carry/zero (and optionally overflow) flags are registered for use by conditional jumps.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_datapath_if.sv | 33 +++
 rtl/alu_adder.sv | 36 +++
 rtl/alu_datapath.sv | 75 +++++++
 tb/tb_alu_datapath.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execution-unit arithmetic datapath.
// Holds the default register width and the select-code enums used by
// the operand-B and write-back multiplexers.
package alu_pkg;

  localparam int REGISTER_DATA_BITS = 8;

  typedef enum logic {
    REGISTER_FILE = 1'b0,
    IMMEDIATE     = 1'b1
  } b_sel_t;

  typedef enum logic [1:0] {
    ALU_OUTPUT     = 2'd0,
    INST_IMMEDIATE = 2'd1,
    MEM_LOAD       = 2'd2,
    REG_FILE_RD0   = 2'd3
  } wb_sel_t;

endpackage

// File: rtl/alu_datapath_if.sv
// Bus bundle between the decode/register-file side (master) and the
// arithmetic datapath (slave). Clock and reset are kept outside.
interface alu_datapath_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] a;
  logic [DATA_BITS-1:0] reg_b;
  logic [DATA_BITS-1:0] imm;
  logic                 b_sel;
  logic                 subtract;
  logic [DATA_BITS-1:0] load_data;
  logic [1:0]           result_sel;
  logic                 flags_en;
  logic [DATA_BITS-1:0] alu_result;
  logic [DATA_BITS-1:0] wb_data;
  logic                 carry;
  logic                 zero;
  logic                 carry_flag;
  logic                 zero_flag;
  logic                 overflow_flag;

  modport master (
    output a, reg_b, imm, b_sel, subtract, load_data, result_sel, flags_en,
    input  alu_result, wb_data, carry, zero, carry_flag, zero_flag, overflow_flag
  );

  modport slave (
    input  a, reg_b, imm, b_sel, subtract, load_data, result_sel, flags_en,
    output alu_result, wb_data, carry, zero, carry_flag, zero_flag, overflow_flag
  );

endinterface

// File: rtl/alu_adder.sv
// Combinational add/subtract core. Subtraction is a + ~b + 1, so carry=1
// means "no borrow". Signed overflow is only built when ALU_OVERFLOW_EN
// is defined; otherwise the overflow output is a constant 0.
module alu_adder
  import alu_pkg::*;
#(
  parameter int DATA_BITS = REGISTER_DATA_BITS
) (
  input  logic [DATA_BITS-1:0] a,
  input  logic [DATA_BITS-1:0] b,
  input  logic                 subtract,
  output logic [DATA_BITS-1:0] result,
  output logic                 carry,
  output logic                 zero,
  output logic                 overflow
);

  localparam int MSB = DATA_BITS - 1;

  logic [DATA_BITS-1:0] b_eff;
  logic [DATA_BITS:0]   sum;

  assign b_eff  = subtract ? ~b : b;
  assign sum    = {1'b0, a} + {1'b0, b_eff} + {{DATA_BITS{1'b0}}, subtract};
  assign result = sum[DATA_BITS-1:0];
  assign carry  = sum[DATA_BITS];
  assign zero   = (result == '0);

`ifdef ALU_OVERFLOW_EN
  // Operands of equal sign producing a result of the other sign.
  assign overflow = (a[MSB] == b_eff[MSB]) && (result[MSB] != a[MSB]);
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: rtl/alu_datapath.sv
// Execution-unit arithmetic datapath: operand-B select, add/sub core,
// write-back select, and the registered carry/zero/overflow flags used
// by conditional jumps. Optional macro: ALU_OVERFLOW_EN builds the
// signed-overflow flag; without it overflow_flag is tied to 0.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int DATA_BITS = REGISTER_DATA_BITS
) (
  input  logic           clk,
  input  logic           reset,
  alu_datapath_if.slave  bus
);

  logic [DATA_BITS-1:0] b_op;
  logic                 ovf;

  logic carry_flag_d, carry_flag_q;
  logic zero_flag_d,  zero_flag_q;
  logic ovf_flag_d,   ovf_flag_q;
  logic armed_d,      armed_q;

  assign b_op = (bus.b_sel == IMMEDIATE) ? bus.imm : bus.reg_b;

  alu_adder #(
    .DATA_BITS (DATA_BITS)
  ) u_adder (
    .a        (bus.a),
    .b        (b_op),
    .subtract (bus.subtract),
    .result   (bus.alu_result),
    .carry    (bus.carry),
    .zero     (bus.zero),
    .overflow (ovf)
  );

  assign bus.wb_data = (bus.result_sel == INST_IMMEDIATE) ? bus.imm       :
                       (bus.result_sel == MEM_LOAD)       ? bus.load_data :
                       (bus.result_sel == REG_FILE_RD0)   ? bus.a         :
                                                            bus.alu_result;

  // Next-state flags: capture on flags_en, but not on the first edge after
  // reset release (armed_q is still 0 there).
  always_comb begin
    armed_d      = 1'b1;
    carry_flag_d = carry_flag_q;
    zero_flag_d  = zero_flag_q;
    ovf_flag_d   = ovf_flag_q;
    if (armed_q && bus.flags_en) begin
      carry_flag_d = bus.carry;
      zero_flag_d  = bus.zero;
      ovf_flag_d   = ovf;
    end
  end

  // Flag register; zero_flag resets to 1 so an early jump-if-not-zero falls through.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed_q      <= 1'b0;
      carry_flag_q <= 1'b0;
      zero_flag_q  <= 1'b1;
      ovf_flag_q   <= 1'b0;
    end else begin
      armed_q      <= armed_d;
      carry_flag_q <= carry_flag_d;
      zero_flag_q  <= zero_flag_d;
      ovf_flag_q   <= ovf_flag_d;
    end
  end

  assign bus.carry_flag    = carry_flag_q;
  assign bus.zero_flag     = zero_flag_q;
  assign bus.overflow_flag = ovf_flag_q;

endmodule

// File: tb/tb_alu_datapath.sv
// Directed scoreboard bench for alu_datapath.
module tb_alu_datapath;

  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic reset  = 1'b1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] alu;
    logic [7:0] wb;
    logic       c;
    logic       z;
    logic       v;
  } exp_t;

  exp_t comb_q[$];
  exp_t flag_q[$];
  exp_t last;
  exp_t flags_model;

  alu_datapath_if #(.DATA_BITS(8)) bus ();

  alu_datapath #(.DATA_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 if (clk_en) clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic exp_t model(logic [7:0] a, logic [7:0] rb, logic [7:0] imm,
                                 logic bs, logic sub, logic [7:0] ld, logic [1:0] rs);
    exp_t e;
    int ua, ub, r, sa, sb, sr;
    logic [7:0] b;
    b  = bs ? imm : rb;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    if (sub) begin
      r    = ua - ub;
      e.c  = (ua >= ub);
      sr   = sa - sb;
    end else begin
      r    = ua + ub;
      e.c  = (r > 255);
      sr   = sa + sb;
    end
    e.alu = r[7:0];
    e.z   = (e.alu == 8'h00);
`ifdef ALU_OVERFLOW_EN
    e.v   = (sr < -128) || (sr > 127);
`else
    e.v   = 1'b0;
`endif
    case (rs)
      2'd0:    e.wb = e.alu;
      2'd1:    e.wb = imm;
      2'd2:    e.wb = ld;
      default: e.wb = a;
    endcase
    e.tag = "";
    return e;
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(string tag, logic [7:0] a, logic [7:0] rb, logic [7:0] imm,
                       logic bs, logic sub, logic [7:0] ld, logic [1:0] rs);
    exp_t e;
    bus.a          = a;
    bus.reg_b      = rb;
    bus.imm        = imm;
    bus.b_sel      = bs;
    bus.subtract   = sub;
    bus.load_data  = ld;
    bus.result_sel = rs;
    e     = model(a, rb, imm, bs, sub, ld, rs);
    e.tag = tag;
    last  = e;
    comb_q.push_back(e);
  endtask

  task automatic check_comb();
    exp_t e;
    #1;
    if (comb_q.size() == 0) begin
      chk("comb_queue_empty", 8'd0, 8'd1);
    end else begin
      e = comb_q.pop_front();
      chk({e.tag, "_alu"},   bus.alu_result, e.alu);
      chk({e.tag, "_wb"},    bus.wb_data,    e.wb);
      chk({e.tag, "_carry"}, {7'd0, bus.carry}, {7'd0, e.c});
      chk({e.tag, "_zero"},  {7'd0, bus.zero},  {7'd0, e.z});
    end
  endtask

  task automatic push_flags(string tag, logic c, logic z, logic v);
    exp_t e;
    e.tag = tag; e.alu = 8'd0; e.wb = 8'd0;
    e.c = c; e.z = z; e.v = v;
    flag_q.push_back(e);
  endtask

  task automatic check_flags();
    exp_t e;
    if (flag_q.size() == 0) begin
      chk("flag_queue_empty", 8'd0, 8'd1);
    end else begin
      e = flag_q.pop_front();
      chk({e.tag, "_cf"}, {7'd0, bus.carry_flag},    {7'd0, e.c});
      chk({e.tag, "_zf"}, {7'd0, bus.zero_flag},     {7'd0, e.z});
      chk({e.tag, "_of"}, {7'd0, bus.overflow_flag}, {7'd0, e.v});
    end
  endtask

  // One flags_en clock capturing the most recently driven operation.
  task automatic capture(string tag);
    bus.flags_en = 1'b1;
    flags_model  = last;
    push_flags(tag, last.c, last.z, last.v);
    @(posedge clk);
    #1;
    bus.flags_en = 1'b0;
    check_flags();
    @(negedge clk);
  endtask

  initial begin
    bus.a = 8'h00; bus.reg_b = 8'h00; bus.imm = 8'h00; bus.b_sel = 1'b0;
    bus.subtract = 1'b0; bus.load_data = 8'h00; bus.result_sel = 2'd0;
    bus.flags_en = 1'b0;

    // Reset with no clock running
    #1 reset = 1'b0;
    #1;
    push_flags("reset_noclk", 1'b0, 1'b1, 1'b0);
    check_flags();

    // Combinational paths work while in reset
    drive("add_in_reset", 8'h10, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0);
    check_comb();

    // Release and run a few edges with flags_en low
    reset  = 1'b1;
    clk_en = 1'b1;
    repeat (3) @(negedge clk);
    push_flags("after_release", 1'b0, 1'b1, 1'b0);
    check_flags();

    // Add register operand
    drive("add_reg", 8'h12, 8'h34, 8'h99, 1'b0, 1'b0, 8'h00, 2'd0);
    check_comb();
    capture("add_reg_flags");

    // Wrap through immediate
    drive("wrap", 8'hFF, 8'h77, 8'h01, 1'b1, 1'b0, 8'h00, 2'd0);
    check_comb();
    capture("wrap_flags");

    // Subtract equal and with borrow
    drive("sub_eq", 8'h05, 8'h00, 8'h05, 1'b1, 1'b1, 8'h00, 2'd0);
    check_comb();
    drive("sub_borrow", 8'h03, 8'h00, 8'h05, 1'b1, 1'b1, 8'h00, 2'd0);
    check_comb();
    capture("sub_borrow_flags");

    // Write-back mux codes, flags must hold with flags_en low
    drive("wb_imm",  8'hAA, 8'h00, 8'h3C, 1'b1, 1'b0, 8'h5A, 2'd1);
    check_comb();
    drive("wb_load", 8'hAA, 8'h00, 8'h3C, 1'b1, 1'b0, 8'h5A, 2'd2);
    check_comb();
    drive("wb_a",    8'hAA, 8'h00, 8'h3C, 1'b1, 1'b0, 8'h5A, 2'd3);
    check_comb();
    drive("wb_alu",  8'hAA, 8'h00, 8'h3C, 1'b1, 1'b0, 8'h5A, 2'd0);
    check_comb();
    @(posedge clk);
    #1;
    push_flags("hold", flags_model.c, flags_model.z, flags_model.v);
    check_flags();
    @(negedge clk);

    // Signed overflow cases
    drive("ovf_add", 8'h7F, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0);
    check_comb();
    capture("ovf_add_flags");
    drive("ovf_sub", 8'h80, 8'h00, 8'h01, 1'b1, 1'b1, 8'h00, 2'd0);
    check_comb();
    capture("ovf_sub_flags");

    // Reset asserted mid-cycle wins over a pending capture
    drive("mid_reset_op", 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0);
    check_comb();
    bus.flags_en = 1'b1;
    #2 reset = 1'b0;
    #1;
    push_flags("mid_reset_async", 1'b0, 1'b1, 1'b0);
    check_flags();
    @(posedge clk);
    #1;
    push_flags("mid_reset_edge", 1'b0, 1'b1, 1'b0);
    check_flags();
    bus.flags_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Capture works again after recovery
    drive("post_reset", 8'h80, 8'h80, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0);
    check_comb();
    capture("post_reset_flags");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
